fir_coeff_ram_ctrl: RTL and testbench
=====================================

// Module: fir_coeff_ram_ctrl
// PURPOSE
//  Sequences and arbitrates the 10x16 single-port coefficient SRAM (SpSram10x16) of the FIR filter.
//  Two requesters share the RAM:
//  - host coefficient-update port: writes;
//  - per-sample tap fetch for the MAC: reads, with priority.
//  Sits between the host register interface, the SRAM and the MAC datapath.
// PARAMETERS
//  TAPS  10  number of filter taps, equal to the RAM depth; addresses 0..TAPS-1
//  AW    4   RAM address width
//  DW    16  RAM data / coefficient width
// PORTS
//  iClk12M     in   1   single 12 MHz clock; all logic on rising edge
//  iRsn        in   1   reset, asynchronous assert, active-low
//  iEnSample   in   1   1-cycle pulse: new input sample, start a tap fetch
//  iUpdReq     in   1   host write request (level, held until oUpdAck)
//  iUpdAddr    in   AW  host write address
//  iUpdData    in   DW  host write data
//  oUpdAck     out  1   1-cycle pulse: the host write is being issued to the RAM this cycle
//  oUpdErr     out  1   1-cycle pulse: write rejected (macro only, else tied 0)
//  oCsnRam     out  1   RAM chip select, active-low
//  oWrnRam     out  1   RAM write enable, active-low
//  oAddrRam    out  AW  RAM address
//  oWtDtRam    out  DW  RAM write data
//  iRdDtRam    in   DW  RAM read data, valid the cycle after the read is sampled
//  oCoeff      out  DW  coefficient to MAC, = iRdDtRam (combinational pass-through)
//  oCoeffVld   out  1   oCoeff valid this cycle
//  oCoeffIdx   out  AW  tap index of oCoeff
//  oLastTap    out  1   high with oCoeffVld when oCoeffIdx==TAPS-1
//  oBusy       out  1   FSM not in IDLE
//  oOverrun    out  1   1-cycle pulse: iEnSample dropped because a fetch was active
// BEHAVIOUR
//  Reset values (async, while iRsn=0):
//  - oCsnRam=1, oWrnRam=1, oAddrRam=0, oWtDtRam=0.
//  - All pulses/valids=0, oCoeffIdx=0, FSM=IDLE, pending flags cleared.
//  - Applies immediately mid-operation; an in-flight fetch is abandoned and no oCoeffVld follows.
//  All RAM-side outputs and status outputs are registered.
//  FSM states: IDLE, WRITE, FETCH, DRAIN.
//  - IDLE: iEnSample=1 -> FETCH, tap cnt=0 (priority). Else iUpdReq=1 -> WRITE.
//  - WRITE: one cycle; oCsnRam=0, oWrnRam=0, oAddrRam=iUpdAddr, oWtDtRam=iUpdData, oUpdAck=1; -> IDLE.
//  - FETCH: oCsnRam=0, oWrnRam=1, oAddrRam=cnt; cnt++ each cycle; after cnt==TAPS-1 -> DRAIN.
//  - DRAIN: one cycle; oCsnRam=1, oWrnRam=1; -> IDLE.
//  Fetch timing:
//  - iEnSample sampled at edge N -> address 0 driven after N.
//  - oCoeffVld/oCoeffIdx=k after edge N+1+k, k=0..TAPS-1.
//  - Back-to-back taps, no bubbles; oBusy low after edge N+TAPS+1.
//  Arbitration:
//  - iUpdReq arriving during FETCH/DRAIN waits; served on the first IDLE cycle without a strobe.
//  - iEnSample and iUpdReq together in IDLE: fetch wins, update waits.
//  - iEnSample in FETCH/DRAIN/WRITE: dropped, oOverrun pulses the next cycle; the active operation is unaffected.
//  Host handshake:
//  - Host must drop iUpdReq the cycle after oUpdAck.
//  - If iUpdReq is still high in IDLE after that, it is served as a new request.
//  Idle RAM outputs: oCsnRam=1, oWrnRam=1; oAddrRam/oWtDtRam hold their last values.
// CONFIGURATION
//  Macro FIR_UPD_ADDR_CHECK_EN:
//  - Defined: in IDLE, iUpdReq with iUpdAddr>=TAPS takes no RAM cycle; oUpdErr=1 and oUpdAck=1 pulse together; FSM stays IDLE.
//  - Undefined: every request is written as given, oUpdErr tied 0.
// STRUCTURE
//  Shared package fir_pkg:
//  - FSM state encoding (IDLE/WRITE/FETCH/DRAIN);
//  - TAPS, AW, DW defaults shared with SpSram10x16 and the MAC.
//  One natural sub-module: fir_tap_cnt.
//  - Tap address counter with clear, enable, terminal-count flag.
//  - Reused by the MAC delay-line addressing.
// TESTING
//  1. Write 0xA01..0xA0A to addrs 0..9 via update port, then iEnSample -> oCoeff 0xA01..0xA0A, idx 0..9 on 10 consecutive cycles; oLastTap only at idx 9.
//  2. iUpdReq addr 3 = 0x1234 one cycle after iEnSample -> oUpdAck after DRAIN; next fetch gives idx 3 = 0x1234.
//  3. iEnSample again during FETCH at idx 4 -> oOverrun one pulse; sequence continues to idx 9 unbroken; no second fetch.
//  4. iEnSample and iUpdReq in the same IDLE cycle -> full fetch first, then one WRITE cycle with oUpdAck.
//  5. iRsn low during FETCH at idx 5 -> oCsnRam=1, oCoeffVld=0 immediately; after release oBusy=0 and the next iEnSample restarts at idx 0.
//  6. iUpdAddr=12 -> with FIR_UPD_ADDR_CHECK_EN: oUpdErr=1, no oCsnRam low; without it: a write cycle to address 12.

Source files
------------

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR coefficient path: default tap count and RAM
// geometry (shared with SpSram10x16 and the MAC), plus the state encoding of
// the coefficient RAM controller.
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_TAPS = 10;  // filter taps == RAM depth
  localparam int FIR_AW   = 4;   // RAM address width
  localparam int FIR_DW   = 16;  // RAM data / coefficient width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FETCH = 2'd2,
    ST_DRAIN = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_tap_cnt.sv
// -----------------------------------------------------------------------------
// fir_tap_cnt
// Tap address counter. Counts 0..TAPS-1 with a synchronous clear (priority)
// and a count enable; wraps to 0 after the terminal count. Also used by the
// MAC delay-line addressing.
//
// Ports
//   clk_i   in   1   clock, rising edge
//   rst_ni  in   1   asynchronous active-low reset
//   clr_i   in   1   load 0 on the next edge (wins over en_i)
//   en_i    in   1   advance by one on the next edge
//   cnt_o   out  AW  current count
//   tc_o    out  1   count equals TAPS-1
// -----------------------------------------------------------------------------
module fir_tap_cnt
  import fir_pkg::*;
#(
  parameter int TAPS = FIR_TAPS,
  parameter int AW   = FIR_AW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [AW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/fir_coeff_ram_ctrl.sv
// -----------------------------------------------------------------------------
// fir_coeff_ram_ctrl
// Sequences and arbitrates the single-port coefficient SRAM of the FIR filter.
// Per-sample tap fetches (reads, TAPS back-to-back cycles) have priority over
// host coefficient updates (single write cycles). All RAM-side and status
// outputs are registered; oCoeff is the RAM read data passed straight through.
//
// Optional feature, macro FIR_UPD_ADDR_CHECK_EN:
//   defined   - an update to an address >= TAPS is rejected without a RAM
//               cycle; oUpdErr and oUpdAck pulse together.
//   undefined - every update is written as given; oUpdErr is tied 0.
//
// Ports
//   iClk12M    in   1   12 MHz clock, rising edge
//   iRsn       in   1   asynchronous active-low reset
//   iEnSample  in   1   pulse: new sample, start a tap fetch
//   iUpdReq    in   1   host write request, held until oUpdAck
//   iUpdAddr   in   AW  host write address
//   iUpdData   in   DW  host write data
//   oUpdAck    out  1   pulse: host write issued to the RAM this cycle
//   oUpdErr    out  1   pulse: host write rejected (address check build only)
//   oCsnRam    out  1   RAM chip select, active-low
//   oWrnRam    out  1   RAM write enable, active-low
//   oAddrRam   out  AW  RAM address
//   oWtDtRam   out  DW  RAM write data
//   iRdDtRam   in   DW  RAM read data, one cycle after the read edge
//   oCoeff     out  DW  coefficient to the MAC (= iRdDtRam)
//   oCoeffVld  out  1   oCoeff valid
//   oCoeffIdx  out  AW  tap index of oCoeff
//   oLastTap   out  1   oCoeffVld for tap TAPS-1
//   oBusy      out  1   controller not idle
//   oOverrun   out  1   pulse: iEnSample dropped because the RAM was busy
// -----------------------------------------------------------------------------
module fir_coeff_ram_ctrl
  import fir_pkg::*;
#(
  parameter int TAPS = FIR_TAPS,
  parameter int AW   = FIR_AW,
  parameter int DW   = FIR_DW
) (
  input  logic          iClk12M,
  input  logic          iRsn,
  input  logic          iEnSample,
  input  logic          iUpdReq,
  input  logic [AW-1:0] iUpdAddr,
  input  logic [DW-1:0] iUpdData,
  output logic          oUpdAck,
  output logic          oUpdErr,
  output logic          oCsnRam,
  output logic          oWrnRam,
  output logic [AW-1:0] oAddrRam,
  output logic [DW-1:0] oWtDtRam,
  input  logic [DW-1:0] iRdDtRam,
  output logic [DW-1:0] oCoeff,
  output logic          oCoeffVld,
  output logic [AW-1:0] oCoeffIdx,
  output logic          oLastTap,
  output logic          oBusy,
  output logic          oOverrun
);

  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

  fir_state_e    state_q;
  logic          csn_q;
  logic          wrn_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdat_q;
  logic          ack_q;
  logic          vld_q;
  logic [AW-1:0] idx_q;
  logic          last_q;
  logic          busy_q;
  logic          ovr_q;

  logic [AW-1:0] cnt;
  logic          cnt_tc;
  logic          fetch_start;
  logic          rd_issued;
  logic          upd_take;
  logic          upd_bad;

  fir_tap_cnt #(
    .TAPS (TAPS),
    .AW   (AW)
  ) u_tap_cnt (
    .clk_i  (iClk12M),
    .rst_ni (iRsn),
    .clr_i  (fetch_start),
    .en_i   (state_q == ST_FETCH && !cnt_tc),
    .cnt_o  (cnt),
    .tc_o   (cnt_tc)
  );

  assign fetch_start = (state_q == ST_IDLE) && iEnSample;
  // A read is in flight whenever the RAM is selected without write enable;
  // its data (and so the coefficient) appears on the following cycle.
  assign rd_issued   = !csn_q && wrn_q;
  // While oUpdAck is showing the host has not yet had a chance to drop its
  // request, so the still-high level is not taken as a second request.
  assign upd_take    = (state_q == ST_IDLE) && !iEnSample && iUpdReq && !ack_q;

`ifdef FIR_UPD_ADDR_CHECK_EN
  localparam logic [AW:0] TAPS_X = (AW+1)'(TAPS);
  assign upd_bad = ({1'b0, iUpdAddr} >= TAPS_X);
`else
  assign upd_bad = 1'b0;
`endif

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= ST_IDLE;
      csn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      addr_q  <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      vld_q  <= rd_issued;
      last_q <= rd_issued && (addr_q == LAST_TAP);
      if (rd_issued) begin
        idx_q <= addr_q;
      end
      // A strobe is only accepted in IDLE; anywhere else it is lost.
      ovr_q <= iEnSample && (state_q != ST_IDLE);

      case (state_q)
        ST_IDLE: begin
          if (fetch_start) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
            csn_q   <= 1'b0;
            wrn_q   <= 1'b1;
            addr_q  <= '0;
          end else if (upd_take) begin
            ack_q <= 1'b1;
            if (!upd_bad) begin
              state_q <= ST_WRITE;
              busy_q  <= 1'b1;
              csn_q   <= 1'b0;
              wrn_q   <= 1'b0;
              addr_q  <= iUpdAddr;
              wdat_q  <= iUpdData;
            end
          end
        end
        ST_WRITE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          csn_q   <= 1'b1;
          wrn_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (cnt_tc) begin
            state_q <= ST_DRAIN;
            csn_q   <= 1'b1;
          end else begin
            addr_q <= cnt + AW'(1);
          end
        end
        ST_DRAIN: begin
          // Last read data is on the bus this cycle; nothing new is issued.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          csn_q   <= 1'b1;
          wrn_q   <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIR_UPD_ADDR_CHECK_EN
  logic err_q;

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= upd_take && upd_bad;
    end
  end

  assign oUpdErr = err_q;
`else
  assign oUpdErr = 1'b0;
`endif

  assign oUpdAck   = ack_q;
  assign oCsnRam   = csn_q;
  assign oWrnRam   = wrn_q;
  assign oAddrRam  = addr_q;
  assign oWtDtRam  = wdat_q;
  assign oCoeff    = iRdDtRam;
  assign oCoeffVld = vld_q;
  assign oCoeffIdx = idx_q;
  assign oLastTap  = last_q;
  assign oBusy     = busy_q;
  assign oOverrun  = ovr_q;

endmodule

// File: tb/tb_fir_coeff_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_ram_ctrl
// Bench for fir_coeff_ram_ctrl with a behavioural SRAM, a cycle-stamp
// reference model of the controller and directed plus random stimulus.
// -----------------------------------------------------------------------------
module tb_fir_coeff_ram_ctrl;

  localparam int TAPS = 10;
  localparam int AW   = 4;
  localparam int DW   = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          req   = 1'b0;
  logic [AW-1:0] uaddr = '0;
  logic [DW-1:0] udata = '0;

  logic          oUpdAck, oUpdErr, oCsnRam, oWrnRam, oCoeffVld, oLastTap, oBusy, oOverrun;
  logic [AW-1:0] oAddrRam, oCoeffIdx;
  logic [DW-1:0] oWtDtRam, oCoeff;
  logic [DW-1:0] rd_q = '0;
  logic [DW-1:0] ram [16] = '{default: '0};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fir_coeff_ram_ctrl dut (
    .iClk12M   (clk),
    .iRsn      (rst_n),
    .iEnSample (en),
    .iUpdReq   (req),
    .iUpdAddr  (uaddr),
    .iUpdData  (udata),
    .oUpdAck   (oUpdAck),
    .oUpdErr   (oUpdErr),
    .oCsnRam   (oCsnRam),
    .oWrnRam   (oWrnRam),
    .oAddrRam  (oAddrRam),
    .oWtDtRam  (oWtDtRam),
    .iRdDtRam  (rd_q),
    .oCoeff    (oCoeff),
    .oCoeffVld (oCoeffVld),
    .oCoeffIdx (oCoeffIdx),
    .oLastTap  (oLastTap),
    .oBusy     (oBusy),
    .oOverrun  (oOverrun)
  );

  // Behavioural single-port SRAM: read data one cycle after the read edge.
  always @(posedge clk) begin
    if (!oCsnRam) begin
      if (!oWrnRam) ram[oAddrRam] <= oWtDtRam;
      else          rd_q <= ram[oAddrRam];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: every operation is a time stamp (edge index). A fetch
  // accepted at edge S drives addresses in cycles S..S+TAPS-1, delivers tap k
  // in cycle S+1+k and keeps the block busy through cycle S+TAPS. A write
  // accepted at edge W occupies cycle W only. A new request is accepted at
  // edge e only if cycle e-1 was not busy.
  // ---------------------------------------------------------------------------
  int            cyc = 0;
  int            s_last = -100, w_last = -100, a_last = -100;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic [DW-1:0] mmem [16] = '{default: '0};
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdat = '0;
  bit            model_on = 1'b0;
  logic          e_csn, e_wrn, e_ack, e_err, e_vld, e_last, e_busy, e_ovr;
  logic [AW-1:0] e_addr, e_idx;
  logic [DW-1:0] e_wdat, e_coeff;

  function automatic bit busy_at(input int c);
    return (c >= s_last && c <= s_last + TAPS) || (c == w_last);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_last = -100; w_last = -100; a_last = -100;
      m_addr = '0; m_wdat = '0; model_on = 1'b0;
    end else begin
      bit free, bad;
      int k;
      cyc++;
      free = !busy_at(cyc - 1);
      bad  = 1'b0;
`ifdef FIR_UPD_ADDR_CHECK_EN
      bad  = (int'(uaddr) >= TAPS);
`endif
      e_ovr = en && !free;
      e_ack = 1'b0;
      e_err = 1'b0;
      if (en && free) begin
        s_last = cyc;
      end else if (free && req && (a_last != cyc - 1)) begin
        a_last = cyc;
        e_ack  = 1'b1;
        if (bad) e_err = 1'b1;
        else begin
          w_last = cyc; w_addr = uaddr; w_data = udata;
          mmem[uaddr] = udata;
        end
      end
      k = cyc - s_last;
      if (k >= 0 && k < TAPS) begin
        e_csn = 1'b0; e_wrn = 1'b1; m_addr = AW'(k);
      end else if (cyc == w_last) begin
        e_csn = 1'b0; e_wrn = 1'b0; m_addr = w_addr; m_wdat = w_data;
      end else begin
        e_csn = 1'b1; e_wrn = 1'b1;
      end
      e_addr  = m_addr;
      e_wdat  = m_wdat;
      e_vld   = (k >= 1 && k <= TAPS);
      e_idx   = e_vld ? AW'(k - 1) : '0;
      e_coeff = e_vld ? mmem[k - 1] : '0;
      e_last  = e_vld && (k == TAPS);
      e_busy  = busy_at(cyc);
      model_on = 1'b1;
    end
  end

  // Compare process: every cycle, half a period after the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_csn", oCsnRam, 1);
      chk("rst_vld", oCoeffVld, 0);
      chk("rst_busy", oBusy, 0);
    end else if (model_on) begin
      chk("m_csn", oCsnRam, e_csn);
      chk("m_wrn", oWrnRam, e_wrn);
      chk("m_addr", oAddrRam, e_addr);
      chk("m_wdat", oWtDtRam, e_wdat);
      chk("m_ack", oUpdAck, e_ack);
      chk("m_err", oUpdErr, e_err);
      chk("m_vld", oCoeffVld, e_vld);
      chk("m_last", oLastTap, e_last);
      chk("m_busy", oBusy, e_busy);
      chk("m_ovr", oOverrun, e_ovr);
      if (e_vld) begin
        chk("m_idx", oCoeffIdx, e_idx);
        chk("m_coeff", oCoeff, e_coeff);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Host / strobe drivers
  // ---------------------------------------------------------------------------
  int            lat;
  logic          at_csn, at_wrn, at_err, csn_seen_low;
  logic [AW-1:0] at_addr;
  logic [DW-1:0] at_wdat;
  logic [DW-1:0] cap [TAPS];
  bit            cap_ok;
  int            ovr_cnt, ovr_k, last_cnt, last_k;
  logic          busy_drain, busy_after;

  task automatic wait_ack();
    bit got = 1'b0;
    lat = 0;
    csn_seen_low = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      lat++;
      if (!oCsnRam) csn_seen_low = 1'b1;
      got = oUpdAck;
    end
    chk("upd_ack_seen", got, 1);
    at_csn = oCsnRam; at_wrn = oWrnRam; at_addr = oAddrRam;
    at_wdat = oWtDtRam; at_err = oUpdErr;
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic host_write(input int a, input logic [DW-1:0] d);
    req = 1'b1; uaddr = AW'(a); udata = d;
    wait_ack();
  endtask

  task automatic fetch_capture(input int ovr_at);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    cap_ok = 1'b1; ovr_cnt = 0; ovr_k = -1; last_cnt = 0; last_k = -1;
    for (int k = 0; k < TAPS; k++) begin
      @(negedge clk);
      if (!(oCoeffVld && oCoeffIdx == AW'(k))) cap_ok = 1'b0;
      cap[k] = oCoeff;
      if (oLastTap) begin last_cnt++; last_k = k; end
      if (oOverrun) begin ovr_cnt++; ovr_k = k; end
      busy_drain = oBusy;
      en = (k == ovr_at);
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) busy_after = oBusy;
      if (oCoeffVld) cap_ok = 1'b0;
      if (oOverrun) begin ovr_cnt++; ovr_k = TAPS + k; end
    end
  endtask

  initial begin
    int rq_age;
    repeat (3) @(negedge clk);
    chk("rst_wrn", oWrnRam, 1);
    chk("rst_addr", oAddrRam, 0);
    chk("rst_wdat", oWtDtRam, 0);
    chk("rst_idx", oCoeffIdx, 0);
    chk("rst_ack", oUpdAck, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: load 0xA01..0xA0A, fetch them back in order
    for (int i = 0; i < TAPS; i++) begin
      host_write(i, DW'(16'hA01 + i));
      if (i == 0) begin
        chk("t1_wr_lat", lat, 1);
        chk("t1_wr_csn", at_csn, 0);
        chk("t1_wr_wrn", at_wrn, 0);
        chk("t1_wr_wdat", at_wdat, 16'hA01);
      end
    end
    fetch_capture(-1);
    chk("t1_seq", cap_ok, 1);
    for (int i = 0; i < TAPS; i++) chk("t1_coeff", cap[i], 16'hA01 + i);
    chk("t1_last_cnt", last_cnt, 1);
    chk("t1_last_idx", last_k, 9);
    chk("t1_busy_drain", busy_drain, 1);
    chk("t1_busy_after", busy_after, 0);

    // 2: update requested one cycle after the strobe waits for the fetch
    en = 1'b1;
    @(negedge clk);
    en = 1'b0; req = 1'b1; uaddr = 4'd3; udata = 16'h1234;
    wait_ack();
    chk("t2_ack_lat", lat, 12);
    chk("t2_addr", at_addr, 3);
    fetch_capture(-1);
    chk("t2_seq", cap_ok, 1);
    chk("t2_idx3", cap[3], 16'h1234);
    chk("t2_idx2", cap[2], 16'hA03);

    // 3: strobe during the fetch at idx 4
    fetch_capture(4);
    chk("t3_seq", cap_ok, 1);
    chk("t3_ovr_cnt", ovr_cnt, 1);
    chk("t3_ovr_when", ovr_k, 5);
    chk("t3_busy_after", busy_after, 0);

    // 4: strobe and update in the same idle cycle
    en = 1'b1; req = 1'b1; uaddr = 4'd7; udata = 16'h0777;
    @(negedge clk);
    en = 1'b0;
    wait_ack();
    chk("t4_ack_lat", lat, 12);
    chk("t4_wr_csn", at_csn, 0);
    chk("t4_wr_addr", at_addr, 7);
    fetch_capture(-1);
    chk("t4_idx7", cap[7], 16'h0777);

    // 5: reset in the middle of a fetch
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_idx_before", oCoeffIdx, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_csn", oCsnRam, 1);
    chk("t5_vld", oCoeffVld, 0);
    chk("t5_busy", oBusy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_busy_rel", oBusy, 0);
    fetch_capture(-1);
    chk("t5_seq", cap_ok, 1);
    chk("t5_idx0", cap[0], 16'hA01);

    // 6: out-of-range update address
    host_write(12, 16'hBEEF);
`ifdef FIR_UPD_ADDR_CHECK_EN
    chk("t6_err", at_err, 1);
    chk("t6_no_cs", csn_seen_low, 0);
`else
    chk("t6_err", at_err, 0);
    chk("t6_csn", at_csn, 0);
    chk("t6_wrn", at_wrn, 0);
    chk("t6_addr", at_addr, 12);
    chk("t6_wdat", at_wdat, 16'hBEEF);
`endif

    // Random traffic against the model
    rq_age = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (req) begin
        if (oUpdAck) req = 1'b0;
        else begin
          rq_age++;
          if (rq_age > 100) begin
            chk("rand_req_starved", rq_age, 0);
            req = 1'b0;
          end
        end
      end else if ($urandom_range(0, 5) == 0) begin
        req = 1'b1; rq_age = 0;
        uaddr = AW'($urandom_range(0, 15));
        udata = DW'($urandom);
      end
      en = ($urandom_range(0, 9) == 0);
    end
    en = 1'b0; req = 1'b0;
    repeat (15) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
